// File: rtl/mau_pkg.sv
// Shared types, size encodings and alignment check for the load/store unit.
package mau_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCESS   = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } mau_state_e;

  // Size 11 is never legal; halves need even, words need 4-byte alignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lo[0];
      SIZE_W:  bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for stores.
module lane_align
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] data,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [31:0] word_b;
  logic [31:0] word_h;

  assign sh_b   = {offset, 3'b000};
  assign sh_h   = {offset[1], 4'b0000};
  assign word_b = word >> sh_b;
  assign word_h = word >> sh_h;

  always_comb begin
    ext    = word;
    merged = data;
    case (size)
      SIZE_B: begin
        ext    = {{24{sign & word_b[7]}}, word_b[7:0]};
        merged = (word & ~(32'h0000_00FF << sh_b)) | ({24'b0, data[7:0]} << sh_b);
      end
      SIZE_H: begin
        ext    = {{16{sign & word_h[15]}}, word_h[15:0]};
        merged = (word & ~(32'h0000_FFFF << sh_h)) | ({16'b0, data[15:0]} << sh_h);
      end
      default: begin
        ext    = word;
        merged = data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, read-modify-write for sub-word stores.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output mau_state_e        dbg_state
);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // resp_valid is a single-cycle pulse with no backpressure.

  mau_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              req_bad;
  logic [DATA_W-1:0] align_word;
  logic [DATA_W-1:0] align_ext;
  logic [DATA_W-1:0] align_merged;

  assign req_bad = misaligned(req_size, req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= SIZE_B;
      sign_q  <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        sign_q  <= req_signed;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= req_bad;
      end
      if (state_q == ACCESS)   rdata_q <= align_ext;
      if (state_q == RMW_READ) merge_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)             state_d = RESP;
          else if (!req_we)        state_d = ACCESS;
          else if (req_size == SIZE_W) state_d = WRITE;
          else                     state_d = RMW_READ;
        end
      end
      ACCESS:   state_d = RESP;
      RMW_READ: state_d = WRITE;
      WRITE:    state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Loads extract from live read data; stores merge into the word captured in RMW_READ.
  assign align_word = (state_q == WRITE) ? merge_q : mem_rdata;

  lane_align u_lane_align (
    .word   (align_word),
    .offset (addr_q[1:0]),
    .size   (size_q),
    .sign   (sign_q),
    .data   (wdata_q),
    .ext    (align_ext),
    .merged (align_merged)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_we     = (state_q == WRITE) && !rst;
  assign mem_wdata  = (state_q == WRITE) ? align_merged : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and response timing checks.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  mau_state_e  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:63];
  int          we_count = 0;
  logic [31:0] we_addr  = '0;
  logic [31:0] we_data  = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // Memory model: combinational read, write on the falling edge.
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:2]] = mem_wdata;
      we_count = we_count + 1;
      we_addr  = mem_addr;
      we_data  = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, then scramble the request inputs; returns response edge count.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int n, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_size   = 2'b11;
    req_signed = ~sgn;
    req_addr   = 32'h0000_0024;
    req_wdata  = 32'hFFFF_FFFF;
    n = 1;
    rdata = '0;
    err = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
      if (n >= 8) begin
        n = -1;
        break;
      end
      @(posedge clk);
      n++;
    end
  endtask

  int          n;
  logic [31:0] rd;
  logic        er;
  int          we_before;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899_AABB;
    mem[5] = 32'h1122_3344;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_rdata", resp_rdata, 32'h0);
    check("reset_err", 32'(resp_err), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);

    we_before = we_count;
    do_req(1'b0, SIZE_B, 1'b1, 32'h11, 32'h0, n, rd, er);
    check("lb_s_lat", 32'(n), 32'd2);
    check("lb_s_data", rd, 32'hFFFF_FFAA);
    check("lb_s_err", 32'(er), 32'd0);
    check("lb_s_no_we", 32'(we_count), 32'(we_before));

    do_req(1'b0, SIZE_H, 1'b0, 32'h12, 32'h0, n, rd, er);
    check("lh_u_lat", 32'(n), 32'd2);
    check("lh_u_data", rd, 32'h0000_8899);
    do_req(1'b0, SIZE_H, 1'b1, 32'h12, 32'h0, n, rd, er);
    check("lh_s_data", rd, 32'hFFFF_8899);
    do_req(1'b0, SIZE_B, 1'b0, 32'h10, 32'h0, n, rd, er);
    check("lb_u_data", rd, 32'h0000_00BB);

    we_before = we_count;
    do_req(1'b1, SIZE_B, 1'b0, 32'h13, 32'h1234_565C, n, rd, er);
    check("sb_lat", 32'(n), 32'd3);
    check("sb_we_count", 32'(we_count), 32'(we_before + 1));
    check("sb_we_addr", we_addr, 32'h10);
    check("sb_we_data", we_data, 32'h5C99_AABB);
    check("sb_rdata", rd, 32'h0);
    check("sb_err", 32'(er), 32'd0);
    do_req(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, n, rd, er);
    check("lw_after_sb", rd, 32'h5C99_AABB);
    mem[4] = 32'h8899_AABB;

    do_req(1'b1, SIZE_H, 1'b0, 32'h12, 32'hFFFF_1234, n, rd, er);
    check("sh_lat", 32'(n), 32'd3);
    check("sh_mem", mem[4], 32'h1234_AABB);
    mem[4] = 32'h8899_AABB;

    we_before = we_count;
    do_req(1'b1, SIZE_W, 1'b0, 32'h14, 32'hCAFE_F00D, n, rd, er);
    check("sw_lat", 32'(n), 32'd2);
    check("sw_mem", mem[5], 32'hCAFE_F00D);
    check("sw_we_count", 32'(we_count), 32'(we_before + 1));
    mem[5] = 32'h1122_3344;

    we_before = we_count;
    do_req(1'b1, SIZE_W, 1'b0, 32'h16, 32'hDEAD_BEEF, n, rd, er);
    check("sw_mis_lat", 32'(n), 32'd1);
    check("sw_mis_err", 32'(er), 32'd1);
    check("sw_mis_rdata", rd, 32'h0);
    do_req(1'b0, SIZE_H, 1'b0, 32'h11, 32'h0, n, rd, er);
    check("lh_mis_lat", 32'(n), 32'd1);
    check("lh_mis_err", 32'(er), 32'd1);
    check("lh_mis_rdata", rd, 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, n, rd, er);
    check("size11_lat", 32'(n), 32'd1);
    check("size11_err", 32'(er), 32'd1);
    check("size11_rdata", rd, 32'h0);
    check("err_no_we", 32'(we_count), 32'(we_before));
    check("err_mem4", mem[4], 32'h8899_AABB);
    check("err_mem5", mem[5], 32'h1122_3344);

    // Reset lands in the WRITE cycle of a word store.
    we_before = we_count;
    @(negedge clk);
    req_we = 1'b1; req_size = SIZE_W; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstw_state", 32'(dbg_state), 32'(WRITE));
    check("rstw_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstw_resp_valid", 32'(resp_valid), 32'd0);
    check("rstw_ready", 32'(req_ready), 32'd1);
    check("rstw_mem", mem[4], 32'h8899_AABB);
    check("rstw_we_count", 32'(we_count), 32'(we_before));

    // Back-to-back word loads with req_valid held high.
    begin
      int acc = 0;
      int resp = 0;
      int acc_cyc [4];
      req_we = 1'b0; req_size = SIZE_W; req_signed = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
        if (c > 0) @(negedge clk);
        if (resp_valid) begin
          resp++;
          check("b2b_data", resp_rdata, 32'h8899_AABB);
        end
        if (req_ready) begin
          if (acc < 4) begin
            acc_cyc[acc] = c;
            acc++;
          end else begin
            req_valid = 1'b0;
          end
        end
      end
      req_valid = 1'b0;
      check("b2b_accepts", 32'(acc), 32'd4);
      check("b2b_resps", 32'(resp), 32'd4);
      for (int k = 1; k < 4; k++)
        if (k < acc) check("b2b_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
